// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the integer register file, used by decode and writeback.
package regfile_pkg;

    typedef enum logic [1:0] {
        RF_INIT,
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    localparam int RF_ZERO_ADDR = '0;

    localparam int RF_N  = 32;
    localparam int RF_W  = 32;
    localparam int RF_NR = 2;
    localparam int RF_NW = 1;

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset clear sweep: walks entries 1..N-1 writing zero, one per cycle, then raises ready.
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter  int N  = RF_N,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            idx_q   <= AW'(1);
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready   <= (state_d == RF_READY);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_INIT:  state_d = RF_CLEAR;
            RF_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(N - 1)) state_d = RF_READY;
            end
            RF_READY: state_d = RF_READY;
            default:  state_d = RF_INIT;
        endcase
    end

    assign clr_en   = (state_q == RF_CLEAR);
    assign clr_addr = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0 and highest-port-wins write arbitration.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int N  = RF_N,
    parameter  int W  = RF_W,
    parameter  int NR = RF_NR,
    parameter  int NW = RF_NW,
    localparam int AW = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NW-1:0]          wen,
    input  logic [NW-1:0][AW-1:0]  waddr,
    input  logic [NW-1:0][W-1:0]   wdata,
    input  logic [NR-1:0][AW-1:0]  raddr,
    output logic [NR-1:0][W-1:0]   rdata,
    output logic                   ready
);

    logic [W-1:0]  regs [N];
    logic          clr_en;
    logic [AW-1:0] clr_addr;

    regfile_init_fsm #(.N(N)) u_init (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Later ports overwrite earlier ones in the loop, so the highest index wins.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs[clr_addr] <= '0;
        end else if (ready) begin
            for (int p = 0; p < NW; p++) begin
                if (wen[p] && (waddr[p] != AW'(RF_ZERO_ADDR))) begin
                    regs[waddr[p]] <= wdata[p];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            rdata[r] = '0;
            if (ready && (raddr[r] != AW'(RF_ZERO_ADDR))) begin
                rdata[r] = regs[raddr[r]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NW; p++) begin
                    if (wen[p] && (waddr[p] == raddr[r])) rdata[r] = wdata[p];
                end
`endif
            end
        end
    end

endmodule
